mem_access_unit: RTL

- Load/store front end between the CPU datapath (MEM stage) and the word-wide data memory.
- Converts a byte address plus access type (LW/LH/LHU/LB/LBU/SW/SH/SB) into word accesses on the memory's ena/wena/addr/wdata/rdata port.
- Sub-word loads: extracts and sign/zero-extends the lane.
- Sub-word stores: two-cycle read-modify-write, because the memory only writes whole words.
- Flags misaligned and out-of-range addresses.

---
 rtl/mem_access_unit_pkg.sv | 34 +++
 rtl/mem_access_unit_lane_mux.sv | 42 ++++
 rtl/mem_access_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared op/state encodings and decode helpers for mem_access_unit
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_load(input op_e op);
        return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
    endfunction

    function automatic logic misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// rtl/mem_access_unit_lane_mux.sv - little-endian lane extract/extend for loads and lane merge for stores
module lane_mux
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  op_e         op,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{lane, 3'b000} +: 8];
        half_lane = lane[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (op)
            OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_data = {24'h0, byte_lane};
            OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_data = {16'h0, half_lane};
            default: load_data = word;
        endcase

        // word is the previously read memory word for SH/SB
        store_word = word;
        case (op)
            OP_SW: store_word = wdata;
            OP_SH: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            OP_SB:   store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end turning byte accesses into word reads/writes with RMW for sub-word stores
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = 32'h10010000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        addr_err,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state, state_nx;
    op_e         op_r;
    logic [1:0]  lane_r;
    logic [31:0] idx_r, wdata_r, merge_reg;
    logic        err_r;

    logic [29:0] word_off;
    logic        range_err, cap_err;
    logic [31:0] lane_word, load_data, store_word;

    assign word_off  = 30'((addr - DATA_BASE) >> 2);
    assign range_err = (addr < DATA_BASE) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
    assign cap_err   = range_err || misaligned(op_e'(op), addr[1:0]);

    assign lane_word = (state == ST_WR) ? merge_reg : mem_rdata;

    lane_mux u_lane_mux (
        .word      (lane_word),
        .lane      (lane_r),
        .op        (op_r),
        .wdata     (wdata_r),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (cap_err)                    state_nx = ST_DONE;
                    else if (op_e'(op) == OP_SW)    state_nx = ST_WR;
                    else                            state_nx = ST_RD;
                end
            end
            ST_RD: begin
                mem_ena  = 1'b1;
                mem_addr = idx_r;
                state_nx = is_load(op_r) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                mem_ena   = 1'b1;
                mem_wena  = 1'b1;
                mem_addr  = idx_r;
                mem_wdata = store_word;
                state_nx  = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // a reset arriving mid-access must never produce a partial write
        if (rst) begin
            mem_ena  = 1'b0;
            mem_wena = 1'b0;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign addr_err = (state == ST_DONE) && err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_LW;
            lane_r    <= 2'b00;
            idx_r     <= 32'h0;
            wdata_r   <= 32'h0;
            merge_reg <= 32'h0;
            err_r     <= 1'b0;
            rdata_out <= 32'h0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_r    <= op_e'(op);
                lane_r  <= addr[1:0];
                idx_r   <= {2'b00, word_off};
                wdata_r <= wdata;
                err_r   <= cap_err;
            end
            if (state == ST_RD) begin
                if (is_load(op_r)) rdata_out <= load_data;
                else               merge_reg <= mem_rdata;
            end
        end
    end

endmodule
